// File: rtl/mux2_arbiter_if.sv
// Handshake bundle for the two-requester arbiter: two producer paths in,
// one registered consumer path out, plus per-requester grant counters.
interface mux2_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] in_1;
  logic             in_1_valid;
  logic             in_1_ready;
  logic [WIDTH-1:0] in_2;
  logic             in_2_valid;
  logic             in_2_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             sel;
  logic [15:0]      grant_cnt_1;
  logic [15:0]      grant_cnt_2;

  modport master (
    output in_1, in_1_valid, in_2, in_2_valid, out_ready,
    input  in_1_ready, in_2_ready, data_out, out_valid, sel,
           grant_cnt_1, grant_cnt_2
  );

  modport slave (
    input  in_1, in_1_valid, in_2, in_2_valid, out_ready,
    output in_1_ready, in_2_ready, data_out, out_valid, sel,
           grant_cnt_1, grant_cnt_2
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin two-way arbiter feeding a one-word output register with
// same-cycle drain/refill and saturating per-requester grant counters.
module mux2_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  mux2_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   data_q;
  logic               sel_q;
  logic               last_grant_q;
  logic [CNT_W-1:0]   cnt_1_q;
  logic [CNT_W-1:0]   cnt_2_q;

  logic               load_en;
  logic               gnt_1;
  logic               gnt_2;

  // Grants depend only on valids, state, out_ready and last grant; never on data.
  always_comb begin
    load_en = 1'b0;
    gnt_1   = 1'b0;
    gnt_2   = 1'b0;
    if (!rst) begin
      load_en = (state_q == EMPTY) || bus.out_ready;
      if (load_en) begin
        if (bus.in_1_valid && bus.in_2_valid) begin
          gnt_1 = last_grant_q;
          gnt_2 = ~last_grant_q;
        end else begin
          gnt_1 = bus.in_1_valid;
          gnt_2 = bus.in_2_valid;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_1_q      <= '0;
      cnt_2_q      <= '0;
    end else begin
      if (gnt_1 || gnt_2) begin
        state_q      <= FULL;
        data_q       <= gnt_2 ? bus.in_2 : bus.in_1;
        sel_q        <= gnt_2;
        last_grant_q <= gnt_2;
        if (gnt_1 && (cnt_1_q != CNT_MAX)) cnt_1_q <= cnt_1_q + CNT_W'(1);
        if (gnt_2 && (cnt_2_q != CNT_MAX)) cnt_2_q <= cnt_2_q + CNT_W'(1);
      end else if ((state_q == FULL) && bus.out_ready) begin
        // Consumer drained the word and nobody refilled it.
        state_q <= EMPTY;
      end
    end
  end

  assign bus.in_1_ready  = gnt_1;
  assign bus.in_2_ready  = gnt_2;
  assign bus.data_out    = data_q;
  assign bus.out_valid   = (state_q == FULL);
  assign bus.sel         = sel_q;
  assign bus.grant_cnt_1 = cnt_1_q;
  assign bus.grant_cnt_2 = cnt_2_q;

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets the data width of both requester paths and the output path.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_1  input  WIDTH  requester 0 data.
REQ-005 in_1_valid  input  1  requester 0 has data on in_1.
REQ-006 in_1_ready  output  1  requester 0 data accepted this cycle when in_1_valid is also high.
REQ-007 in_2  input  WIDTH  requester 1 data.
REQ-008 in_2_valid  input  1  requester 1 has data on in_2.
REQ-009 in_2_ready  output  1  requester 1 data accepted this cycle when in_2_valid is also high.
REQ-010 data_out  output  WIDTH  registered selected data.
REQ-011 out_valid  output  1  data_out holds an unconsumed word.
REQ-012 out_ready  input  1  consumer accepts data_out this cycle when out_valid is high.
REQ-013 sel  output  1  source of the word in data_out: 0 = in_1, 1 = in_2 (same encoding as mux2_1 sel).
REQ-014 grant_cnt_1, grant_cnt_2  output  16 each  saturating counts of words accepted from each requester.

Function
REQ-015 State machine SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en SHALL be 1 in EMPTY, and 1 in FULL only when out_ready=1 (same-cycle drain and refill); otherwise 0.
REQ-017 Arbitration is combinational and gated by load_en: exactly one valid requester is granted; if both are valid, the requester not in last_grant is granted.
REQ-018 in_1_ready/in_2_ready SHALL be high only for the granted requester while load_en=1; at most one is high in any cycle.
REQ-019 On an accepted transfer, at the next edge: data_out <= granted data, sel <= granted index, last_grant <= granted index, out_valid <= 1, and that requester's grant counter increments.
REQ-020 In FULL with out_ready=1 and no valid requester: go to EMPTY; out_valid <= 0; data_out, sel and last_grant hold.
REQ-021 In FULL with out_ready=0: data_out, sel and out_valid SHALL hold; both in_*_ready are 0.
REQ-022 Latency SHALL be 1 cycle from acceptance to out_valid; sustained throughput is 1 word per cycle when out_ready is held high.
REQ-023 Grant counters SHALL saturate at 16'hFFFF and never wrap.
REQ-024 in_*_ready SHALL NOT depend on in_*_data; it depends only on valids, state, out_ready and last_grant.
REQ-025 Data of a non-granted requester SHALL never reach data_out.

Reset
REQ-026 While rst=1, asynchronously: state=EMPTY, out_valid=0, data_out=0, sel=0, last_grant=1 (so requester 0 wins the first tie), grant counters=0.
REQ-027 Reset asserted mid-transfer SHALL discard the held word; in_*_ready SHALL be 0 while rst=1.
REQ-028 After rst deasserts, the first edge SHALL be able to accept a transfer.

Verification
REQ-029 Single requester: in_1=31, in_1_valid=1 for one cycle, out_ready=1 -> next cycle data_out=31, sel=0, out_valid=1, grant_cnt_1=1.
REQ-030 Tie after reset: in_1=61, in_2=187, both valid, out_ready=1 -> outputs 61 (sel=0), then 187 (sel=1), alternating while both remain valid.
REQ-031 Backpressure: FULL with data_out=127, out_ready=0 for 5 cycles, both requesters valid -> data_out=127 and sel held, both readies 0; on out_ready=1, refill in the same cycle.
REQ-032 Drain: FULL, out_ready=1, no valids -> out_valid=0 next cycle, data_out unchanged.
REQ-033 Saturation: force 65536 accepts from requester 1 -> grant_cnt_2=16'hFFFF, grant_cnt_1 unchanged.
REQ-034 Reset mid-operation: rst pulsed while FULL with data_out=187 -> out_valid=0, data_out=0, sel=0 immediately; the next tie grants requester 0.
